// File: rtl/lsh_pkg.sv
// Shared definitions for the LSH front end (sketch_builder and hash_table).
package lsh_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } lsh_state_e;

    localparam logic [31:0] H2_MULT = 32'h9E3779B1;

    localparam int SKETCH_SIZE_DEF         = 16;
    localparam int NUM_OF_BUCKETS_DEF      = 256;
    localparam int LOG2_NUM_OF_BUCKETS_DEF = 8;

    // Width needed to count 0..n valid slots.
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sketch_builder_if.sv
// K-mer stream in, hashed sketch out. master = upstream/consumer side, slave = sketch_builder.
interface sketch_builder_if
    import lsh_pkg::*;
#(
    parameter int SKETCH_SIZE         = SKETCH_SIZE_DEF,
    parameter int LOG2_NUM_OF_BUCKETS = LOG2_NUM_OF_BUCKETS_DEF
);
    localparam int FILL_W = fill_width(SKETCH_SIZE);

    logic [31:0]                                    kmerHash;
    logic                                           kmerValid;
    logic                                           kmerLast;
    logic                                           kmerReady;
    logic                                           modeQuery;
    logic [31:0]                                    windowIdIn;
    logic                                           isInsert;
    logic                                           isQuery;
    logic [31:0]                                    windowID;
    logic [0:SKETCH_SIZE-1][LOG2_NUM_OF_BUCKETS-1:0] hashedSketch;
    logic [FILL_W-1:0]                              sketchFill;

    modport master (
        output kmerHash, kmerValid, kmerLast, modeQuery, windowIdIn,
        input  kmerReady, isInsert, isQuery, windowID, hashedSketch, sketchFill
    );

    modport slave (
        input  kmerHash, kmerValid, kmerLast, modeQuery, windowIdIn,
        output kmerReady, isInsert, isQuery, windowID, hashedSketch, sketchFill
    );

endinterface

// File: rtl/sketch_h2.sv
// Second-level hash mapping a kept minimum to a bucket index.
// SKETCH_H2_MIX_EN selects the multiplicative mix; otherwise the low bits are used directly.
module sketch_h2
    import lsh_pkg::*;
#(
    parameter int LOG2_NUM_OF_BUCKETS = LOG2_NUM_OF_BUCKETS_DEF,
    parameter int NUM_OF_BUCKETS      = NUM_OF_BUCKETS_DEF
) (
    input  logic [31:0]                    value,
    output logic [LOG2_NUM_OF_BUCKETS-1:0] bucket
);
    localparam logic [LOG2_NUM_OF_BUCKETS-1:0] BUCKET_MASK =
        LOG2_NUM_OF_BUCKETS'(NUM_OF_BUCKETS - 1);

    logic [LOG2_NUM_OF_BUCKETS-1:0] raw;

`ifdef SKETCH_H2_MIX_EN
    logic [31:0] product;
    logic        unused_low;

    assign product    = value * H2_MULT;
    assign raw        = product[31:32-LOG2_NUM_OF_BUCKETS];
    assign unused_low = ^product[31-LOG2_NUM_OF_BUCKETS:0];
`else
    logic unused_high;

    assign raw         = value[LOG2_NUM_OF_BUCKETS-1:0];
    assign unused_high = ^value[31:LOG2_NUM_OF_BUCKETS];
`endif

    assign bucket = raw & BUCKET_MASK;

endmodule

// File: rtl/sketch_builder.sv
// Streaming min-hash sketch: keeps the SKETCH_SIZE smallest distinct k-mer hashes of a window
// in a sorted array and emits their h2 buckets once per window (h2 variant set by SKETCH_H2_MIX_EN).
module sketch_builder
    import lsh_pkg::*;
#(
    parameter int SKETCH_SIZE         = SKETCH_SIZE_DEF,
    parameter int NUM_OF_BUCKETS      = NUM_OF_BUCKETS_DEF,
    parameter int LOG2_NUM_OF_BUCKETS = LOG2_NUM_OF_BUCKETS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    sketch_builder_if.slave sb
);
    localparam int                FILL_W = fill_width(SKETCH_SIZE);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(SKETCH_SIZE);

    lsh_state_e state_q, state_d;

    logic [SKETCH_SIZE-1:0][31:0] entry_q, entry_d;
    logic [SKETCH_SIZE-1:0][31:0] shifted, next_entry;
    logic [FILL_W-1:0]            fill_q, fill_d, fill_post;
    logic                         mode_q, mode_d;
    logic [31:0]                  win_q, win_d;

    logic                                            ready_q, ready_d;
    logic                                            is_insert_q, is_insert_d;
    logic                                            is_query_q, is_query_d;
    logic [31:0]                                     window_id_q, window_id_d;
    logic [0:SKETCH_SIZE-1][LOG2_NUM_OF_BUCKETS-1:0] hashed_q, hashed_d;
    logic [FILL_W-1:0]                               sketch_fill_q, sketch_fill_d;

    logic [SKETCH_SIZE-1:0]                          slot_valid, below, equal;
    logic [SKETCH_SIZE-1:0][LOG2_NUM_OF_BUCKETS-1:0] h2_out;
    logic                                            accept, do_insert;

    assign accept = sb.kmerValid && ready_q;

    // Array is sorted ascending, so the slots holding values below the new one form a prefix;
    // the new value lands right after that prefix and everything beyond shifts up by one.
    generate
        for (genvar gi = 0; gi < SKETCH_SIZE; gi++) begin : g_slot
            assign slot_valid[gi] = FILL_W'(gi) < fill_q;
            assign below[gi]      = slot_valid[gi] && (entry_q[gi] < sb.kmerHash);
            assign equal[gi]      = slot_valid[gi] && (entry_q[gi] == sb.kmerHash);

            if (gi == 0) begin : g_head
                assign shifted[gi] = below[gi] ? entry_q[gi] : sb.kmerHash;
            end else begin : g_body
                assign shifted[gi] = below[gi]     ? entry_q[gi] :
                                     below[gi - 1] ? sb.kmerHash : entry_q[gi - 1];
            end

            assign next_entry[gi] = do_insert ? shifted[gi] : entry_q[gi];

            sketch_h2 #(
                .LOG2_NUM_OF_BUCKETS (LOG2_NUM_OF_BUCKETS),
                .NUM_OF_BUCKETS      (NUM_OF_BUCKETS)
            ) u_h2 (
                .value  (entry_q[gi]),
                .bucket (h2_out[gi])
            );
        end
    endgenerate

    // A full array with the last slot below the new value means the value is too large to keep.
    assign do_insert = accept && !(|equal) && !below[SKETCH_SIZE-1];
    assign fill_post = (do_insert && fill_q != FULL) ? fill_q + FILL_W'(1) : fill_q;

    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        fill_d        = fill_q;
        mode_d        = mode_q;
        win_d         = win_q;
        is_insert_d   = 1'b0;
        is_query_d    = 1'b0;
        window_id_d   = window_id_q;
        hashed_d      = hashed_q;
        sketch_fill_d = sketch_fill_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    entry_d = next_entry;
                    fill_d  = fill_post;
                    state_d = COLLECT;
                    if (state_q == IDLE) begin
                        mode_d = sb.modeQuery;
                        win_d  = sb.windowIdIn;
                    end
                    if (sb.kmerLast) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                is_insert_d   = !mode_q;
                is_query_d    = mode_q;
                window_id_d   = win_q;
                sketch_fill_d = fill_q;
                for (int i = 0; i < SKETCH_SIZE; i++) begin
                    hashed_d[i] = slot_valid[i] ? h2_out[i] : '0;
                end
                fill_d  = '0;
                state_d = IDLE;
            end
            default: begin
                fill_d  = '0;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            entry_q       <= '0;
            fill_q        <= '0;
            mode_q        <= 1'b0;
            win_q         <= '0;
            ready_q       <= 1'b0;
            is_insert_q   <= 1'b0;
            is_query_q    <= 1'b0;
            window_id_q   <= '0;
            hashed_q      <= '0;
            sketch_fill_q <= '0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            fill_q        <= fill_d;
            mode_q        <= mode_d;
            win_q         <= win_d;
            ready_q       <= ready_d;
            is_insert_q   <= is_insert_d;
            is_query_q    <= is_query_d;
            window_id_q   <= window_id_d;
            hashed_q      <= hashed_d;
            sketch_fill_q <= sketch_fill_d;
        end
    end

    assign sb.kmerReady    = ready_q;
    assign sb.isInsert     = is_insert_q;
    assign sb.isQuery      = is_query_q;
    assign sb.windowID     = window_id_q;
    assign sb.hashedSketch = hashed_q;
    assign sb.sketchFill   = sketch_fill_q;

endmodule

// File: tb/tb_sketch_builder.sv
// Directed bench for sketch_builder: window emit, dedup, overflow, back-to-back and reset cases.
module tb_sketch_builder;

    typedef logic [0:15][7:0] hs_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    sketch_builder_if #(.SKETCH_SIZE(16), .LOG2_NUM_OF_BUCKETS(8)) sb ();

    sketch_builder #(
        .SKETCH_SIZE         (16),
        .NUM_OF_BUCKETS      (256),
        .LOG2_NUM_OF_BUCKETS (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [7:0] h2m(input logic [31:0] v);
`ifdef SKETCH_H2_MIX_EN
        logic [31:0] p;
        p = v * 32'h9E3779B1;
        return p[31:24];
`else
        return v[7:0];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] h, input logic last, input logic m,
                           input logic [31:0] w);
        sb.kmerValid  = 1'b1;
        sb.kmerHash   = h;
        sb.kmerLast   = last;
        sb.modeQuery  = m;
        sb.windowIdIn = w;
    endtask

    task automatic send(input logic [31:0] h, input logic last, input logic m,
                        input logic [31:0] w);
        int waited;
        waited = 0;
        present(h, last, m, w);
        while (!sb.kmerReady && waited < 8) begin
            tick();
            waited++;
        end
        if (!sb.kmerReady) check("send_ready", {127'd0, sb.kmerReady}, 128'd1);
        tick();
        sb.kmerValid = 1'b0;
        sb.kmerLast  = 1'b0;
    endtask

    // Called on the negedge right after the last element's accepting edge.
    task automatic expect_emit(input string tag, input logic qry, input logic [31:0] win,
                               input logic [4:0] fill, input hs_t hs);
        check({tag, "_ready_emit"}, {127'd0, sb.kmerReady}, 128'd0);
        check({tag, "_early_pulse"}, {126'd0, sb.isInsert, sb.isQuery}, 128'd0);
        tick();
        check({tag, "_pulse"}, {126'd0, sb.isInsert, sb.isQuery}, {126'd0, !qry, qry});
        check({tag, "_winid"}, {96'd0, sb.windowID}, {96'd0, win});
        check({tag, "_fill"}, {123'd0, sb.sketchFill}, {123'd0, fill});
        check({tag, "_sketch"}, sb.hashedSketch, hs);
        check({tag, "_ready_back"}, {127'd0, sb.kmerReady}, 128'd1);
        tick();
        check({tag, "_pulse_end"}, {126'd0, sb.isInsert, sb.isQuery}, 128'd0);
        check({tag, "_hold"}, sb.hashedSketch, hs);
    endtask

    initial begin
        hs_t exp_hs;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        sb.kmerValid  = 1'b0;
        sb.kmerHash   = '0;
        sb.kmerLast   = 1'b0;
        sb.modeQuery  = 1'b0;
        sb.windowIdIn = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready", {127'd0, sb.kmerReady}, 128'd0);
        check("rst_pulse", {126'd0, sb.isInsert, sb.isQuery}, 128'd0);
        check("rst_winid", {96'd0, sb.windowID}, 128'd0);
        check("rst_fill", {123'd0, sb.sketchFill}, 128'd0);
        check("rst_sketch", sb.hashedSketch, 128'd0);
        reset = 1'b0;
        tick();
        check("rst_ready_after", {127'd0, sb.kmerReady}, 128'd1);

        // Insert window 100..81 descending: the 16 smallest are 81..96
        for (int v = 100; v >= 81; v--) send(32'(v), v == 81, 1'b0, 32'd14);
        for (int i = 0; i < 16; i++) exp_hs[i] = h2m(32'(81 + i));
        expect_emit("desc", 1'b0, 32'd14, 5'd16, exp_hs);

        // Query window with duplicates
        send(32'd5, 1'b0, 1'b1, 32'h22);
        send(32'd5, 1'b0, 1'b0, 32'h99);
        send(32'd5, 1'b0, 1'b0, 32'h99);
        send(32'd3, 1'b1, 1'b0, 32'h99);
        exp_hs = '0;
        exp_hs[0] = h2m(32'd3);
        exp_hs[1] = h2m(32'd5);
        expect_emit("dup", 1'b1, 32'h22, 5'd2, exp_hs);

        // Single-element window
        send(32'h1FF, 1'b1, 1'b0, 32'd7);
        exp_hs = '0;
        exp_hs[0] = h2m(32'h1FF);
        expect_emit("single", 1'b0, 32'd7, 5'd1, exp_hs);

        // Value 1: exercises the h2 mixing constant when enabled
        send(32'd1, 1'b1, 1'b1, 32'd8);
        exp_hs = '0;
`ifdef SKETCH_H2_MIX_EN
        exp_hs[0] = 8'h9E;
`else
        exp_hs[0] = 8'h01;
`endif
        expect_emit("one", 1'b1, 32'd8, 5'd1, exp_hs);

        // All-ones is an ordinary, largest value
        send(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h30);
        send(32'h0, 1'b0, 1'b1, 32'h31);
        send(32'hFFFF_FFFF, 1'b1, 1'b1, 32'h31);
        exp_hs = '0;
        exp_hs[0] = h2m(32'h0);
        exp_hs[1] = h2m(32'hFFFF_FFFF);
        expect_emit("ones", 1'b0, 32'h30, 5'd2, exp_hs);

        // Back-to-back windows with kmerValid held high
        present(32'd10, 1'b0, 1'b0, 32'hA);
        check("b2b_ready_a0", {127'd0, sb.kmerReady}, 128'd1);
        tick();
        present(32'd20, 1'b0, 1'b1, 32'hFF);
        tick();
        present(32'd30, 1'b1, 1'b1, 32'hFF);
        tick();
        check("b2b_dead", {127'd0, sb.kmerReady}, 128'd0);
        present(32'd40, 1'b0, 1'b1, 32'hB);
        tick();
        exp_hs = '0;
        exp_hs[0] = h2m(32'd10);
        exp_hs[1] = h2m(32'd20);
        exp_hs[2] = h2m(32'd30);
        check("b2b_a_pulse", {126'd0, sb.isInsert, sb.isQuery}, 128'd2);
        check("b2b_a_winid", {96'd0, sb.windowID}, 128'hA);
        check("b2b_a_fill", {123'd0, sb.sketchFill}, 128'd3);
        check("b2b_a_sketch", sb.hashedSketch, exp_hs);
        check("b2b_ready_b0", {127'd0, sb.kmerReady}, 128'd1);
        tick();
        present(32'd50, 1'b1, 1'b0, 32'hC);
        check("b2b_a_pulse_end", {126'd0, sb.isInsert, sb.isQuery}, 128'd0);
        tick();
        sb.kmerValid = 1'b0;
        sb.kmerLast  = 1'b0;
        check("b2b_dead2", {127'd0, sb.kmerReady}, 128'd0);
        tick();
        exp_hs = '0;
        exp_hs[0] = h2m(32'd40);
        exp_hs[1] = h2m(32'd50);
        check("b2b_b_pulse", {126'd0, sb.isInsert, sb.isQuery}, 128'd1);
        check("b2b_b_winid", {96'd0, sb.windowID}, 128'hB);
        check("b2b_b_fill", {123'd0, sb.sketchFill}, 128'd2);
        check("b2b_b_sketch", sb.hashedSketch, exp_hs);
        tick();

        // Reset in the middle of a window
        for (int v = 1; v <= 7; v++) send(32'(v), 1'b0, 1'b0, 32'h55);
        reset = 1'b1;
        tick();
        check("mid_rst_ready", {127'd0, sb.kmerReady}, 128'd0);
        check("mid_rst_pulse", {126'd0, sb.isInsert, sb.isQuery}, 128'd0);
        check("mid_rst_fill", {123'd0, sb.sketchFill}, 128'd0);
        check("mid_rst_winid", {96'd0, sb.windowID}, 128'd0);
        check("mid_rst_sketch", sb.hashedSketch, 128'd0);
        reset = 1'b0;
        tick();
        check("mid_rst_ready_after", {127'd0, sb.kmerReady}, 128'd1);
        tick();
        check("mid_rst_no_pulse", {126'd0, sb.isInsert, sb.isQuery}, 128'd0);
        send(32'd200, 1'b1, 1'b1, 32'h66);
        exp_hs = '0;
        exp_hs[0] = h2m(32'd200);
        expect_emit("post_rst", 1'b1, 32'h66, 5'd1, exp_hs);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sketch_builder.md
# sketch_builder

Streaming min-hash sketch generator placed directly upstream of `hash_table`. It accepts one 32-bit k-mer hash per cycle for a window and keeps the SKETCH_SIZE smallest distinct values in a sorted register array. On the window's last element it applies h2 to each kept value and presents `hashedSketch` with a one-cycle `isInsert` or `isQuery` pulse. `hash_table` consumes that pulse on the following clock edge.

## Interface
- SKETCH_SIZE, 16, number of minima kept and number of `hashedSketch` slots
- NUM_OF_BUCKETS, 256, hash table bucket count
- LOG2_NUM_OF_BUCKETS, 8, width of each `hashedSketch` slot
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- kmerHash  in  32  k-mer hash value
- kmerValid  in  1  kmerHash valid
- kmerLast  in  1  marks the final k-mer of the window; qualified by kmerValid
- kmerReady  out  1  builder accepts the element on an edge where kmerValid && kmerReady
- modeQuery  in  1  0 = insert window, 1 = query window; latched with the window's first accepted element
- windowIdIn  in  32  window ID; latched with the first accepted element
- isInsert  out  1  one-cycle pulse, sketch valid, insert
- isQuery  out  1  one-cycle pulse, sketch valid, query
- windowID  out  32  latched window ID
- hashedSketch  out  LOG2_NUM_OF_BUCKETS x [0:SKETCH_SIZE-1]  h2 of kept minima, ascending raw-value order
- sketchFill  out  $clog2(SKETCH_SIZE+1)  number of valid slots in hashedSketch

## Operation
- States: IDLE, COLLECT, EMIT.
- IDLE: array empty. The first accepted element latches modeQuery and windowIdIn, is inserted, and moves the FSM to COLLECT. If that element also has kmerLast, the FSM moves to EMIT.
- COLLECT: each accepted element is compared in parallel against all valid entries.
  - Equal to any valid entry: dropped.
  - Array not full: shift-inserted in sorted position.
  - Array full and value < entry[SKETCH_SIZE-1]: shift-inserted; the largest entry is discarded.
  - Array full and value >= largest entry: dropped.
  - An accepted element with kmerLast moves the FSM to EMIT.
- EMIT: kmerReady=0. Outputs are registered from the array.
  - hashedSketch[i] = h2(entry[i]) for valid slots, 0 for unfilled slots.
  - sketchFill = count of valid entries.
  - isInsert = !mode, isQuery = mode; exactly one is high, for exactly one cycle.
  - Next cycle: array cleared, FSM to IDLE.
- kmerReady = 1 in IDLE and COLLECT.
- Value comparison is unsigned 32-bit. 32'hFFFFFFFF is an ordinary value.

## Timing
- Insertion is single-cycle; the element accepted at edge N is visible in the array after edge N.
- Last element accepted at edge N: isInsert/isQuery, hashedSketch, windowID and sketchFill are valid from edge N+1 to edge N+2. hash_table samples them at edge N+2.
- Minimum window-to-window spacing: one dead cycle (EMIT). The next window's first element is accepted at edge N+2.
- windowID and hashedSketch hold their values after the pulse until the next EMIT.
- Reset values: isInsert=0, isQuery=0, kmerReady=0 during reset and 1 from the first cycle after reset, windowID=0, hashedSketch all 0, sketchFill=0, array empty, state IDLE.
- Reset mid-window or during EMIT: the window is discarded, no pulse is issued, all outputs take their reset values.
- Single-element window (first element has kmerLast): EMIT with sketchFill=1.

## Configuration
- `SKETCH_H2_MIX_EN` defined: h2(v) = bits [31:32-LOG2_NUM_OF_BUCKETS] of (v * 32'h9E3779B1), truncated to 32 bits.
- `SKETCH_H2_MIX_EN` undefined: h2(v) = v[LOG2_NUM_OF_BUCKETS-1:0].

## Structure
- Shared package `lsh_pkg` holds:
  - state enum {IDLE, COLLECT, EMIT}
  - H2 multiplier constant 32'h9E3779B1
  - default SKETCH_SIZE / LOG2_NUM_OF_BUCKETS constants, also used by hash_table
- Sub-module `sketch_h2`: combinational, one 32-bit value in, LOG2_NUM_OF_BUCKETS bits out, contains the macro switch. It is instantiated SKETCH_SIZE times.

## Test plan
- Insert window, 20 elements 100..81 descending, last on 81, macro off, SKETCH_SIZE=16 -> single isInsert pulse; sketchFill=16; hashedSketch = 81..96 low 8 bits; windowID = latched value (14).
- Query window {5,5,5,3} with modeQuery=1 -> isQuery only; sketchFill=2; slots {3,5,0,...}; isInsert stays 0.
- Single element 0x1FF with kmerLast -> EMIT the next edge; sketchFill=1; slot0=0xFF with macro off; kmerReady=0 for exactly one cycle.
- Back-to-back windows with kmerValid held high -> exactly one dead cycle; second window's modeQuery/windowIdIn latched independently.
- Reset asserted mid-COLLECT after 7 elements -> no pulse; sketchFill=0 after reset; next window unaffected by stale entries.
- Macro on, value 1 -> slot = 0x9E (upper 8 bits of 0x9E3779B1).
